vga_fb_arbiter: RTL

Single-port framebuffer RAM arbiter between the VGA scan-out path and a host port. It sits between the `vga` timing core (consuming its `hdata`/`vdata`/`de`), a synchronous single-port RAM, and the host bus. Display reads own the RAM during every active-video cycle. Host writes are buffered in a FIFO, and host writes and reads are served only in blanking cycles. The framebuffer base address is latched once per frame, so page flips are tear-free.

---
 rtl/vga_fb_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display scan-out owns the RAM during active
// video; buffered host writes, then host reads, are served in blanking.
module vga_fb_arbiter #(
    parameter int AW        = 20,
    parameter int DW        = 16,
    parameter int FIFO_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 de,
    input  logic [11:0]          hdata,
    input  logic [11:0]          vdata,
    input  logic [AW-1:0]        fb_base,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic [DW-1:0]        pix_data,
    output logic                 pix_de,
    input  logic                 host_wr_valid,
    output logic                 host_wr_ready,
    input  logic [AW-1:0]        host_wr_addr,
    input  logic [DW-1:0]        host_wr_data,
    input  logic                 host_rd_valid,
    output logic                 host_rd_ready,
    input  logic [AW-1:0]        host_rd_addr,
    output logic [DW-1:0]        host_rd_data,
    output logic                 host_rd_data_valid,
    output logic [FIFO_LOG2:0]   fifo_level
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] FULL_COUNT = (FIFO_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DISP, S_WR, S_RD} state_t;
    state_t state_reg, state_next;

    logic [AW+DW-1:0]     fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_LOG2:0]   count_reg;
    logic [AW-1:0]        ofs_reg, base_reg;
    logic                 rd_pending_reg, rd_busy_reg;
    logic [AW-1:0]        rd_addr_reg;
    logic                 disp_d_reg, rd_d_reg;

    logic                 fifo_empty, push, pop, frame_start, rd_accept;
    logic [AW-1:0]        disp_addr;
    logic [AW+DW-1:0]     fifo_head;
    logic                 mem_en_next, mem_we_next;
    logic [AW-1:0]        mem_addr_next;
    logic [DW-1:0]        mem_wdata_next;

    assign fifo_empty    = (count_reg == '0);
    assign host_wr_ready = (count_reg != FULL_COUNT);
    assign host_rd_ready = !rd_busy_reg;
    assign fifo_level    = count_reg;
    assign push          = host_wr_valid && host_wr_ready;
    assign pop           = (state_next == S_WR);
    assign rd_accept     = host_rd_valid && !rd_busy_reg;
    assign fifo_head     = fifo_mem[rd_ptr_reg];

    // The first pixel of a frame uses the incoming base directly so a page flip
    // takes effect on that very pixel.
    assign frame_start = de && (hdata == 12'd0) && (vdata == 12'd0);
    assign disp_addr   = frame_start ? fb_base : base_reg + ofs_reg;

    always_comb begin
        state_next     = S_IDLE;
        mem_en_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = '0;
        mem_wdata_next = '0;
        if (de) begin
            state_next    = S_DISP;
            mem_en_next   = 1'b1;
            mem_addr_next = disp_addr;
        end else if (!fifo_empty) begin
            state_next     = S_WR;
            mem_en_next    = 1'b1;
            mem_we_next    = 1'b1;
            mem_addr_next  = fifo_head[AW+DW-1:DW];
            mem_wdata_next = fifo_head[DW-1:0];
        end else if (rd_pending_reg) begin
            state_next    = S_RD;
            mem_en_next   = 1'b1;
            mem_addr_next = rd_addr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {host_wr_addr, host_wr_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg          <= S_IDLE;
            mem_en             <= 1'b0;
            mem_we             <= 1'b0;
            mem_addr           <= '0;
            mem_wdata          <= '0;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
            ofs_reg            <= '0;
            base_reg           <= '0;
            rd_pending_reg     <= 1'b0;
            rd_busy_reg        <= 1'b0;
            rd_addr_reg        <= '0;
            disp_d_reg         <= 1'b0;
            rd_d_reg           <= 1'b0;
            pix_de             <= 1'b0;
            pix_data           <= '0;
            host_rd_data       <= '0;
            host_rd_data_valid <= 1'b0;
        end else begin
            state_reg <= state_next;
            mem_en    <= mem_en_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;

            if (de)
                ofs_reg <= frame_start ? AW'(1) : ofs_reg + AW'(1);
            if (frame_start)
                base_reg <= fb_base;

            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;

            // Busy spans acceptance through the response pulse: one read in flight.
            if (rd_accept) begin
                rd_busy_reg    <= 1'b1;
                rd_pending_reg <= 1'b1;
                rd_addr_reg    <= host_rd_addr;
            end else begin
                if (state_next == S_RD)
                    rd_pending_reg <= 1'b0;
                if (host_rd_data_valid)
                    rd_busy_reg <= 1'b0;
            end

            disp_d_reg         <= (state_reg == S_DISP);
            rd_d_reg           <= (state_reg == S_RD);
            pix_de             <= disp_d_reg;
            pix_data           <= disp_d_reg ? mem_rdata : '0;
            host_rd_data_valid <= rd_d_reg;
            if (rd_d_reg)
                host_rd_data <= mem_rdata;
        end
    end
endmodule
